// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file datapath: vector layout, register count,
// default requester count and the crypto-engine sizing constants.
package rf_wb_arbiter_pkg;

  localparam int unsigned NCOEFF       = 4;   // coefficients per vector
  localparam int unsigned COEFFW       = 16;  // bits per coefficient
  localparam int unsigned NPRIMES      = 2;
  localparam int unsigned NCIPHERS     = 2;
  localparam int unsigned NREG         = 32;  // architectural vector registers
  localparam int unsigned NREQ_DEFAULT = 4;   // FU result streams sharing writeback

  typedef logic [NCOEFF-1:0][COEFFW-1:0] vec_t;

  // Width of a pointer into n entries; never zero.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Circular priority picker: returns the first set bit of mask, searching
// upward from start and wrapping from NREQ-1 back to 0.
module rf_wb_arbiter_rr_pick
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned PTRW = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [PTRW-1:0] start,
  output logic            found,
  output logic [PTRW-1:0] index
);

  // Walk the NREQ positions in circular order; the first hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned j;
      j = 32'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && mask[j[PTRW-1:0]]) begin
        found = 1'b1;
        index = j[PTRW-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: grants up to two FU result streams per cycle in
// round-robin order and registers them onto the register-file write ports.
// The two ports never carry the same destination register in one cycle.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  localparam int unsigned IDXW = $clog2(NREG),
  localparam int unsigned PTRW = ptr_width(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rf_ready,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][IDXW-1:0] req_dest,
  input  vec_t [NREQ-1:0]           req_data,
  output logic                      dest0_valid,
  output logic [IDXW-1:0]           dest0_register_index,
  output vec_t                      dest0_coefficient,
  output logic                      dest1_valid,
  output logic [IDXW-1:0]           dest1_register_index,
  output vec_t                      dest1_coefficient
);

  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;

  logic            grant_en;
  logic [NREQ-1:0] mask0, mask1;
  logic            g0_found, g1_found;
  logic [PTRW-1:0] g0_idx, g1_idx, start1;

  // No grants while the register file stalls or reset is held, so a requester
  // never sees a handshake that the output stage will not take.
  assign grant_en = rf_ready & ~reset;
  assign mask0    = grant_en ? req_valid : '0;

  rf_wb_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick0 (
    .mask  (mask0),
    .start (rr_ptr_q),
    .found (g0_found),
    .index (g0_idx)
  );

  // Second search resumes just after g0 and drops g0 itself plus any
  // requester aiming at the same register as g0.
  always_comb begin
    start1 = (g0_idx == PTRW'(NREQ - 1)) ? '0 : g0_idx + 1'b1;
    mask1  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      mask1[i] = mask0[i] && g0_found && (PTRW'(i) != g0_idx) &&
                 (req_dest[i] != req_dest[g0_idx]);
    end
  end

  rf_wb_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick1 (
    .mask  (mask1),
    .start (start1),
    .found (g1_found),
    .index (g1_idx)
  );

  // One-hot grants and the next round-robin start point.
  always_comb begin
    req_ready = '0;
    if (g0_found) req_ready[g0_idx] = 1'b1;
    if (g1_found) req_ready[g1_idx] = 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (g1_found) begin
      rr_ptr_d = (g1_idx == PTRW'(NREQ - 1)) ? '0 : g1_idx + 1'b1;
    end else if (g0_found) begin
      rr_ptr_d = (g0_idx == PTRW'(NREQ - 1)) ? '0 : g0_idx + 1'b1;
    end
  end

  // Pointer and output registers; payload registers only load on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q             <= '0;
      dest0_valid          <= 1'b0;
      dest0_register_index <= '0;
      dest0_coefficient    <= '0;
      dest1_valid          <= 1'b0;
      dest1_register_index <= '0;
      dest1_coefficient    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      dest0_valid <= g0_found;
      dest1_valid <= g1_found;
      if (g0_found) begin
        dest0_register_index <= req_dest[g0_idx];
        dest0_coefficient    <= req_data[g0_idx];
      end
      if (g1_found) begin
        dest1_register_index <= req_dest[g1_idx];
        dest1_coefficient    <= req_data[g1_idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a list-based reference model predicts
// grants and register-file writes; a monitor compares the output stage.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned IDXW = $clog2(NREG);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   rf_ready = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0][IDXW-1:0] req_dest = '0;
  vec_t [N-1:0]           req_data = '0;
  logic                   dest0_valid, dest1_valid;
  logic [IDXW-1:0]        dest0_register_index, dest1_register_index;
  vec_t                   dest0_coefficient, dest1_coefficient;

  rf_wb_arbiter #(.NREQ(N)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rf_ready             (rf_ready),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_dest             (req_dest),
    .req_data             (req_data),
    .dest0_valid          (dest0_valid),
    .dest0_register_index (dest0_register_index),
    .dest0_coefficient    (dest0_coefficient),
    .dest1_valid          (dest1_valid),
    .dest1_register_index (dest1_register_index),
    .dest1_coefficient    (dest1_coefficient)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v0;
    logic [IDXW-1:0] i0;
    vec_t            d0;
    logic            v1;
    logic [IDXW-1:0] i1;
    vec_t            d1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Requester-side state (what each FU is presenting).
  logic            v[N];
  logic [IDXW-1:0] dst[N];
  vec_t            dat[N];

  // Reference model state.
  int              m_ptr;
  logic            m_v0, m_v1;
  logic [IDXW-1:0] m_i0, m_i1;
  vec_t            m_d0, m_d1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int c = 0; c < NCOEFF; c++) r[c] = COEFFW'($urandom());
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0; m_d0 = '0; m_d1 = '0;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_dest[i]  = dst[i];
      req_data[i]  = dat[i];
    end
  endtask

  // One clock cycle: present inputs, predict, let the edge happen, retire grants.
  task automatic step();
    int   order[$];
    int   g0, g1;
    bit   f0, f1;
    logic [N-1:0] exp_rdy;
    exp_t e;
    apply();
    #1;
    f0 = 0; f1 = 0; g0 = 0; g1 = 0;
    if (!reset && rf_ready) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (v[i]) order.push_back(i);
      end
      if (order.size() > 0) begin
        f0 = 1;
        g0 = order[0];
        for (int k = 1; k < order.size(); k++)
          if (!f1 && dst[order[k]] != dst[g0]) begin
            f1 = 1;
            g1 = order[k];
          end
      end
    end
    exp_rdy = '0;
    if (f0) exp_rdy[g0] = 1'b1;
    if (f1) exp_rdy[g1] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    if (!reset) begin
      m_v0 = f0;
      m_v1 = f1;
      if (f0) begin m_i0 = dst[g0]; m_d0 = dat[g0]; end
      if (f1) begin m_i1 = dst[g1]; m_d1 = dat[g1]; end
      if (f1) m_ptr = (g1 + 1) % N;
      else if (f0) m_ptr = (g0 + 1) % N;
    end
    e = '{v0: m_v0, i0: m_i0, d0: m_d0, v1: m_v1, i1: m_i1, d1: m_d1};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (f0) v[g0] = 0;
    if (f1) v[g1] = 0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_dest0_valid", 128'(dest0_valid), 128'(0));
    chk("rst_dest1_valid", 128'(dest1_valid), 128'(0));
    chk("rst_dest0_index", 128'(dest0_register_index), 128'(0));
    chk("rst_dest1_coeff", 128'(dest1_coefficient), 128'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Bounded: unretired requests after the budget count as a failure.
  task automatic drain();
    int pend;
    rf_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      pend = 0;
      for (int i = 0; i < N; i++) pend += int'(v[i]);
      if (pend == 0) break;
      step();
    end
    pend = 0;
    for (int i = 0; i < N; i++) pend += int'(v[i]);
    chk("drain_pending", 128'(pend), 128'(0));
  endtask

  // Monitor: compare the output stage against the queued prediction.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("dest0_valid", 128'(dest0_valid), 128'(mon_e.v0));
      chk("dest0_index", 128'(dest0_register_index), 128'(mon_e.i0));
      chk("dest0_coeff", 128'(dest0_coefficient), 128'(mon_e.d0));
      chk("dest1_valid", 128'(dest1_valid), 128'(mon_e.v1));
      chk("dest1_index", 128'(dest1_register_index), 128'(mon_e.i1));
      chk("dest1_coeff", 128'(dest1_coefficient), 128'(mon_e.d1));
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin v[i] = 0; dst[i] = '0; dat[i] = '0; end

    // Reset and rf_ready gating.
    for (int i = 0; i < N; i++) begin v[i] = 1; dst[i] = IDXW'(i + 1); dat[i] = rnd_vec(); end
    apply();
    @(negedge clk);
    chk("gate_ready_in_reset", 128'(req_ready), 128'(0));
    chk("gate_d0v_in_reset", 128'(dest0_valid), 128'(0));
    chk("gate_d1v_in_reset", 128'(dest1_valid), 128'(0));
    reset = 1'b0;
    rf_ready = 1'b0;
    step();
    step();
    rf_ready = 1'b1;
    step();
    drain();

    // Dual grant, pointer wraps back to 0.
    reset_dut();
    v[1] = 1; dst[1] = 5; dat[1] = rnd_vec();
    v[3] = 1; dst[3] = 9; dat[3] = rnd_vec();
    step();
    chk("dual_dest0_index", 128'(dest0_register_index), 128'(5));
    chk("dual_dest1_index", 128'(dest1_register_index), 128'(9));

    // Same-destination conflict.
    v[0] = 1; dst[0] = 7; dat[0] = rnd_vec();
    v[2] = 1; dst[2] = 7; dat[2] = rnd_vec();
    step();
    chk("conflict_d1v", 128'(dest1_valid), 128'(0));
    step();
    drain();

    // Fairness with all four held and distinct dests, then reset mid-stream.
    reset_dut();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        if (!v[i]) begin v[i] = 1; dst[i] = IDXW'(10 + i); dat[i] = rnd_vec(); end
      step();
    end
    chk("midrst_pre_d0v", 128'(dest0_valid), 128'(1));
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_async_d0v", 128'(dest0_valid), 128'(0));
    chk("midrst_async_d0c", 128'(dest0_coefficient), 128'(0));
    step();
    reset = 1'b0;
    for (int t = 0; t < 3; t++) step();
    drain();

    // Single requester, data changing after each grant.
    for (int t = 0; t < 3; t++) begin
      v[2] = 1; dst[2] = 3; dat[2] = rnd_vec();
      step();
    end

    // Randomized traffic with small dest range to force conflicts.
    for (int t = 0; t < 400; t++) begin
      rf_ready = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1; dst[i] = IDXW'($urandom_range(0, 3)); dat[i] = rnd_vec();
        end
      step();
    end
    drain();
    @(posedge clk);
    #2;
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
